ptw_mem_arbiter: RTL and testbench
==================================

// Module: ptw_mem_arbiter
// PURPOSE
//  Shares one memory port between the MMU page-table walker and the core data-memory stage.
//  - Consumes the walker's addr/ren; returns rdata and mmu_stall.
//  - Consumes the core dmem request; returns dmem_rdata and dmem_stall.
//  - Issues one transaction at a time on a valid/ready request, resp_valid response bus.
// PARAMETERS
//  ADDR_W   64   address width, all ports
//  DATA_W   64   data width; one PTE per beat
//  MASK_W   8    byte-write-mask width (DATA_W/8)
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, synchronous, active-low
//  ptw_ren        in   1       walker read request, level-held
//  ptw_addr       in   ADDR_W  PTE address
//  ptw_rdata      out  DATA_W  PTE data, valid while ptw_stall=0 and ptw_ren=1
//  ptw_stall      out  1       walker wait; drives the MMU's mmu_stall
//  dmem_req       in   1       core request, level-held until done
//  dmem_we        in   1       1 = write
//  dmem_addr      in   ADDR_W  core address
//  dmem_wdata     in   DATA_W  write data
//  dmem_wmask     in   MASK_W  byte enables
//  dmem_rdata     out  DATA_W  read data, valid while dmem_stall=0 and dmem_req=1
//  dmem_stall     out  1       core wait
//  mem_req_valid  out  1       downstream request valid
//  mem_req_ready  in   1       downstream accepts request
//  mem_we         out  1       write
//  mem_addr       out  ADDR_W  address
//  mem_wdata      out  DATA_W  write data
//  mem_wmask      out  MASK_W  byte enables
//  mem_resp_valid in   1       one-cycle response strobe, reads and writes
//  mem_rdata      in   DATA_W  response data
// BEHAVIOUR
//  - Reset values:
//    - state IDLE; mem_req_valid=0; mem_we=0; mem_addr/wdata/wmask=0.
//    - ptw_rdata=0, dmem_rdata=0; done flags 0; last_grant=DMEM.
//  - FSM IDLE -> REQ -> RESP -> IDLE:
//    - IDLE: a pending requester is one with its request high and its done flag clear.
//      - If any requester is pending, register the grant, drive the mem_* fields, set mem_req_valid; go to REQ.
//      - PTW requests: mem_we=0, wmask=0, mem_addr={ptw_addr[ADDR_W-1:3],3'b0}.
//    - REQ: hold mem_* stable while mem_req_valid=1 and mem_req_ready=0.
//      - On ready, clear mem_req_valid the next cycle and go to RESP.
//    - RESP: on mem_resp_valid, latch mem_rdata into the granted port's rdata register.
//      - Set that port's done flag; go to IDLE.
//  - Arbitration when both are pending in IDLE:
//    - Grant the port that did not win last (alternating). last_grant updates on every grant.
//    - A single pending port always wins.
//  - Stall: ptw_stall = ptw_ren & ~ptw_done; dmem_stall = dmem_req & ~dmem_done. Both are combinational.
//  - Done flags are one-shot: set on response, cleared the following cycle. Each requester sees exactly one stall-low cycle.
//    - The walker advances on that cycle and presents its next PTE address.
//  - Minimum latency, request seen in IDLE at cycle 0:
//    - mem_req_valid high in cycle 1; ready in cycle 1 gives RESP in cycle 2.
//    - resp_valid in cycle k gives stall low in cycle k+1.
//  - Abort: if the granted requester drops its request before the response arrives, the FSM still completes the bus transaction.
//    - The response is discarded: no rdata update, no done flag.
//    - This covers the walker being killed by an M-mode switch.
//  - Back-to-back: IDLE may re-grant in the same cycle a done flag clears, to the other port.
//    - The just-served port is not re-granted until its done flag has cleared.
//  - No IDLE bubble is added after a discarded response.
//  - Reset mid-transaction: the FSM returns to IDLE; late mem_resp_valid in IDLE is ignored.
//  - Address, data and mask widths pass through unchanged; no width conversion.
// STRUCTURE
//  - Shared package xpart_mem_pkg:
//    - arb_state_t {IDLE,REQ,RESP}
//    - grant_t {GRANT_PTW,GRANT_DMEM}
//    - PTE_ALIGN_BITS=3
//  - One sub-module arb_resp_slot holds {rdata register, one-shot done flag} with a capture strobe.
//    - Instantiated once per requester port.
// TESTING
//  - Walker read only: ptw_ren=1, ptw_addr=0x8000_1008; mem ready at once, resp 3 cycles later with 0xAB.
//    - Expect mem_addr=0x8000_1008 and mem_we=0.
//    - Expect ptw_stall low for exactly 1 cycle with ptw_rdata=0xAB.
//  - Three-level walk: the model changes addr on each stall-low cycle.
//    - Expect 3 distinct mem transactions, each ptw_rdata matching, stall high between them.
//  - Contention: ptw_ren and dmem_req (write 0x11 to 0x100, mask 0x0F) both rise in the same cycle, last_grant=DMEM.
//    - PTW is served first, then DMEM.
//    - Expect mem_we=1 and mem_wmask=0x0F on the second transaction.
//  - Backpressure: mem_req_ready low 5 cycles.
//    - Expect mem_req_valid and all mem_* stable for those 5 cycles.
//    - Expect a single handshake and no duplicate request.
//  - Abort: drop ptw_ren in RESP; response 0xDEAD arrives.
//    - Expect ptw_rdata unchanged and no done pulse; a pending dmem request is granted next.
//  - Reset while in REQ: expect mem_req_valid=0 the next cycle, state IDLE, and a stray resp_valid ignored.

Source files
------------

// File: rtl/xpart_mem_pkg.sv
// Shared types for the walker/data-memory port arbiter: FSM states, grant encoding,
// PTE alignment and the alternating-priority pick.
package xpart_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_PTW  = 1'b0,
      GRANT_DMEM = 1'b1
   } grant_t;

   localparam int unsigned PTE_ALIGN_BITS = 3;

   // With both ports pending, the one that did not win last time gets the port.
   function automatic grant_t pick_grant(input logic ptw_pend, input logic dmem_pend,
                                         input grant_t last_grant);
      grant_t g;
      if (ptw_pend && dmem_pend) begin
         g = (last_grant == GRANT_DMEM) ? GRANT_PTW : GRANT_DMEM;
      end else if (ptw_pend) begin
         g = GRANT_PTW;
      end else begin
         g = GRANT_DMEM;
      end
      return g;
   endfunction

endpackage

// File: rtl/arb_resp_slot.sv
// Per-requester response slot: read-data register plus a done flag that is high for
// exactly the one cycle following a capture strobe.
module arb_resp_slot #(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic [DATA_W-1:0] capture_data,
   output logic [DATA_W-1:0] rdata,
   output logic              done
);

   // Data held until the next accepted response; done is a pure one-shot.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata <= {DATA_W{1'b0}};
         done  <= 1'b0;
      end else begin
         done <= capture;
         if (capture) begin
            rdata <= capture_data;
         end
      end
   end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares one valid/ready memory port between the MMU page-table walker and the core
// data-memory stage, one transaction at a time, alternating priority under contention.
module ptw_mem_arbiter
   import xpart_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned MASK_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ptw_ren,
   input  logic [ADDR_W-1:0] ptw_addr,
   output logic [DATA_W-1:0] ptw_rdata,
   output logic              ptw_stall,
   input  logic              dmem_req,
   input  logic              dmem_we,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_wdata,
   input  logic [MASK_W-1:0] dmem_wmask,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_stall,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] PTE_MASK =
      {{(ADDR_W-PTE_ALIGN_BITS){1'b1}}, {PTE_ALIGN_BITS{1'b0}}};

   arb_state_t        state_r, state_s;
   grant_t            grant_r, grant_s;
   grant_t            last_grant_r, last_grant_s;
   logic              aborted_r, aborted_s;
   logic              req_valid_s, we_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] wdata_s;
   logic [MASK_W-1:0] wmask_s;
   logic              ptw_done_s, dmem_done_s;
   logic              ptw_pend_s, dmem_pend_s, granted_req_s;
   logic              ptw_capture_s, dmem_capture_s;

   assign ptw_stall     = ptw_ren & ~ptw_done_s;
   assign dmem_stall    = dmem_req & ~dmem_done_s;
   assign ptw_pend_s    = ptw_stall;
   assign dmem_pend_s   = dmem_stall;
   assign granted_req_s = (grant_r == GRANT_PTW) ? ptw_ren : dmem_req;

   // Next-state, next request fields and response capture strobes.
   always_comb begin
      state_s        = state_r;
      grant_s        = grant_r;
      last_grant_s   = last_grant_r;
      aborted_s      = aborted_r;
      req_valid_s    = mem_req_valid;
      we_s           = mem_we;
      addr_s         = mem_addr;
      wdata_s        = mem_wdata;
      wmask_s        = mem_wmask;
      ptw_capture_s  = 1'b0;
      dmem_capture_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (ptw_pend_s || dmem_pend_s) begin
               grant_s      = pick_grant(ptw_pend_s, dmem_pend_s, last_grant_r);
               last_grant_s = grant_s;
               aborted_s    = 1'b0;
               req_valid_s  = 1'b1;
               state_s      = REQ;
               if (grant_s == GRANT_PTW) begin
                  we_s    = 1'b0;
                  addr_s  = ptw_addr & PTE_MASK;
                  wdata_s = {DATA_W{1'b0}};
                  wmask_s = {MASK_W{1'b0}};
               end else begin
                  we_s    = dmem_we;
                  addr_s  = dmem_addr;
                  wdata_s = dmem_wdata;
                  wmask_s = dmem_wmask;
               end
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            // A requester that lets go at any point before its response forfeits it.
            aborted_s = aborted_r | ~granted_req_s;
            if (mem_req_ready) begin
               req_valid_s = 1'b0;
               state_s     = RESP;
            end else begin
               state_s = REQ;
            end
         end
         RESP: begin
            aborted_s = aborted_r | ~granted_req_s;
            if (mem_resp_valid) begin
               state_s = IDLE;
               if (!aborted_s) begin
                  ptw_capture_s  = (grant_r == GRANT_PTW);
                  dmem_capture_s = (grant_r == GRANT_DMEM);
               end else begin
                  ptw_capture_s  = 1'b0;
                  dmem_capture_s = 1'b0;
               end
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s     = IDLE;
            req_valid_s = 1'b0;
         end
      endcase
   end

   // FSM and downstream request registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= IDLE;
         grant_r       <= GRANT_DMEM;
         last_grant_r  <= GRANT_DMEM;
         aborted_r     <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= {ADDR_W{1'b0}};
         mem_wdata     <= {DATA_W{1'b0}};
         mem_wmask     <= {MASK_W{1'b0}};
      end else begin
         state_r       <= state_s;
         grant_r       <= grant_s;
         last_grant_r  <= last_grant_s;
         aborted_r     <= aborted_s;
         mem_req_valid <= req_valid_s;
         mem_we        <= we_s;
         mem_addr      <= addr_s;
         mem_wdata     <= wdata_s;
         mem_wmask     <= wmask_s;
      end
   end

   arb_resp_slot #(.DATA_W(DATA_W)) u_ptw_slot (
      .clk          (clk),
      .rst          (rst),
      .capture      (ptw_capture_s),
      .capture_data (mem_rdata),
      .rdata        (ptw_rdata),
      .done         (ptw_done_s)
   );

   arb_resp_slot #(.DATA_W(DATA_W)) u_dmem_slot (
      .clk          (clk),
      .rst          (rst),
      .capture      (dmem_capture_s),
      .capture_data (mem_rdata),
      .rdata        (dmem_rdata),
      .done         (dmem_done_s)
   );

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ptw_mem_arbiter;

   localparam logic [63:0] K = 64'hA5A5_0000_5A5A_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        ptw_ren, dmem_req, dmem_we, mem_req_ready, mem_resp_valid;
   logic [63:0] ptw_addr, dmem_addr, dmem_wdata, mem_rdata;
   logic [7:0]  dmem_wmask;
   logic [63:0] ptw_rdata, dmem_rdata, mem_addr, mem_wdata;
   logic        ptw_stall, dmem_stall, mem_req_valid, mem_we;
   logic [7:0]  mem_wmask;

   always #5 clk = ~clk;

   ptw_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .ptw_ren(ptw_ren), .ptw_addr(ptw_addr), .ptw_rdata(ptw_rdata), .ptw_stall(ptw_stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata), .dmem_stall(dmem_stall),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one outstanding transaction record plus per-port result state.
   bit          m_busy, m_acc, m_owner, m_last, m_abort;   // owner/last: 0 = walker, 1 = dmem
   bit          m_valid, m_we, m_pdone, m_ddone;
   logic [63:0] m_addr, m_wdata, m_pdata, m_ddata;
   logic [7:0]  m_wmask;

   bit          auto_mem;
   int          hs_count;
   bit          obs_hs, obs_valid, obs_we, obs_ptw_stall, obs_dmem_stall;
   logic [63:0] obs_addr, obs_wdata, obs_ptw_rdata, obs_dmem_rdata;
   logic [7:0]  obs_wmask;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_acc = 0; m_owner = 1; m_last = 1; m_abort = 0;
      m_valid = 0; m_we = 0; m_pdone = 0; m_ddone = 0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_pdata = '0; m_ddata = '0;
   endtask

   // Advance the model by one clock using the inputs that were stable across the edge.
   task automatic model_step();
      bit pp, dp, np, nd;
      np = 0; nd = 0;
      if (!rst) begin
         model_reset();
         return;
      end
      if (!m_busy) begin
         pp = ptw_ren && !m_pdone;
         dp = dmem_req && !m_ddone;
         if (pp || dp) begin
            m_owner = (pp && dp) ? !m_last : dp;
            m_last = m_owner; m_busy = 1; m_acc = 0; m_abort = 0; m_valid = 1;
            if (!m_owner) begin
               m_we = 0; m_addr = {ptw_addr[63:3], 3'b000}; m_wdata = '0; m_wmask = '0;
            end else begin
               m_we = dmem_we; m_addr = dmem_addr; m_wdata = dmem_wdata; m_wmask = dmem_wmask;
            end
         end
      end else begin
         if (!(m_owner ? dmem_req : ptw_ren)) m_abort = 1;
         if (!m_acc) begin
            if (mem_req_ready) begin m_acc = 1; m_valid = 0; end
         end else if (mem_resp_valid) begin
            m_busy = 0;
            if (!m_abort) begin
               if (m_owner) begin m_ddata = mem_rdata; nd = 1; end
               else begin m_pdata = mem_rdata; np = 1; end
            end
         end
      end
      m_pdone = np;
      m_ddone = nd;
   endtask

   task automatic check_all();
      chk("mem_req_valid", mem_req_valid, m_valid);
      if (m_valid) begin
         chk("mem_we", mem_we, m_we);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
         chk("mem_wmask", mem_wmask, m_wmask);
      end
      chk("ptw_stall", ptw_stall, ptw_ren && !m_pdone);
      chk("dmem_stall", dmem_stall, dmem_req && !m_ddone);
      chk("ptw_rdata", ptw_rdata, m_pdata);
      chk("dmem_rdata", dmem_rdata, m_ddata);
   endtask

   // One cycle: called at a falling edge with inputs set; returns at the next falling edge.
   task automatic tick();
      if (auto_mem) begin
         mem_req_ready = ($urandom_range(0, 1) == 1);
         if (m_busy && m_acc) mem_resp_valid = ($urandom_range(0, 2) == 0);
         else                 mem_resp_valid = ($urandom_range(0, 15) == 0);
         mem_rdata = m_addr ^ K;
      end
      #1;
      check_all();
      obs_valid = mem_req_valid; obs_hs = mem_req_valid && mem_req_ready;
      obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wmask = mem_wmask;
      obs_ptw_stall = ptw_stall; obs_dmem_stall = dmem_stall;
      obs_ptw_rdata = ptw_rdata; obs_dmem_rdata = dmem_rdata;
      if (obs_hs) hs_count++;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Requester behaviour: drop or re-request after service; optionally abort or raise.
   task automatic drive_reqs(input bit keep_going);
      if (ptw_ren && !obs_ptw_stall) begin
         if (keep_going && $urandom_range(0, 1) == 1) ptw_addr = {$urandom, $urandom};
         else ptw_ren = 0;
      end else if (ptw_ren && keep_going && $urandom_range(0, 39) == 0) begin
         ptw_ren = 0;
      end else if (!ptw_ren && keep_going && $urandom_range(0, 3) == 0) begin
         ptw_ren = 1; ptw_addr = {$urandom, $urandom};
      end
      if (dmem_req && !obs_dmem_stall) begin
         dmem_req = keep_going && ($urandom_range(0, 1) == 1);
         dmem_we = $urandom_range(0, 1); dmem_addr = {$urandom, $urandom};
         dmem_wdata = {$urandom, $urandom}; dmem_wmask = 8'($urandom);
      end else if (dmem_req && keep_going && $urandom_range(0, 39) == 0) begin
         dmem_req = 0;
      end else if (!dmem_req && keep_going && $urandom_range(0, 3) == 0) begin
         dmem_req = 1; dmem_we = $urandom_range(0, 1); dmem_addr = {$urandom, $urandom};
         dmem_wdata = {$urandom, $urandom}; dmem_wmask = 8'($urandom);
      end
   endtask

   task automatic drain();
      bit idle_reached = 0;
      auto_mem = 1;
      for (int i = 0; i < 300; i++) begin
         drive_reqs(1'b0);
         tick();
         if (!ptw_ren && !dmem_req && !m_busy) begin idle_reached = 1; break; end
      end
      chk("drain_idle", idle_reached, 1'b1);
   endtask

   initial begin
      logic [63:0] walk [3];
      logic [63:0] got_addr, saved;
      logic [63:0] hs_addr [4], hs_wdata [4];
      logic [7:0]  hs_mask [4];
      bit          hs_we [4];
      int          n, hs0;
      bit          served;

      rst = 0; ptw_ren = 0; ptw_addr = '0; dmem_req = 0; dmem_we = 0; dmem_addr = '0;
      dmem_wdata = '0; dmem_wmask = '0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
      auto_mem = 0; hs_count = 0;
      model_reset();
      @(posedge clk); @(negedge clk);
      tick();
      chk("reset_valid", obs_valid, 1'b0);
      chk("reset_addr", obs_addr, 64'h0);
      chk("reset_ptw_rdata", obs_ptw_rdata, 64'h0);
      chk("reset_dmem_rdata", obs_dmem_rdata, 64'h0);
      rst = 1;

      // Walker read only, response three cycles after acceptance.
      ptw_ren = 1; ptw_addr = 64'h8000_1008; mem_req_ready = 1;
      tick();
      tick();
      chk("t1_valid", obs_valid, 1'b1);
      chk("t1_addr", obs_addr, 64'h8000_1008);
      chk("t1_we", obs_we, 1'b0);
      mem_req_ready = 0;
      tick(); tick();
      mem_resp_valid = 1; mem_rdata = 64'hAB;
      tick();
      mem_resp_valid = 0;
      tick();
      chk("t1_stall_low", obs_ptw_stall, 1'b0);
      chk("t1_rdata", obs_ptw_rdata, 64'hAB);
      tick();
      chk("t1_stall_high_again", obs_ptw_stall, 1'b1);
      ptw_ren = 0;
      drain();

      // Three-level walk: next PTE address presented after each stall-low cycle.
      walk[0] = 64'h8000_2000; walk[1] = 64'h8000_3008; walk[2] = 64'h8000_4010;
      auto_mem = 1;
      for (int lvl = 0; lvl < 3; lvl++) begin
         ptw_ren = 1; ptw_addr = walk[lvl]; hs0 = hs_count; served = 0; got_addr = '0;
         for (int c = 0; c < 200; c++) begin
            tick();
            if (obs_hs) got_addr = obs_addr;
            if (!obs_ptw_stall) begin served = 1; break; end
         end
         chk("walk_served", served, 1'b1);
         chk("walk_one_txn", hs_count - hs0, 64'd1);
         chk("walk_addr", got_addr, walk[lvl]);
         chk("walk_rdata", obs_ptw_rdata, walk[lvl] ^ K);
      end
      ptw_ren = 0;
      drain();

      // Contention with last grant = dmem (fresh from reset): walker first, then the write.
      rst = 0; tick(); rst = 1;
      ptw_ren = 1; ptw_addr = 64'h2000;
      dmem_req = 1; dmem_we = 1; dmem_addr = 64'h100; dmem_wdata = 64'h11; dmem_wmask = 8'h0F;
      auto_mem = 1; n = 0;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (obs_hs) begin
            if (n < 4) begin
               hs_addr[n] = obs_addr; hs_we[n] = obs_we; hs_mask[n] = obs_wmask; hs_wdata[n] = obs_wdata;
            end
            n++;
         end
         if (ptw_ren && !obs_ptw_stall) ptw_ren = 0;
         if (dmem_req && !obs_dmem_stall) dmem_req = 0;
         if (!ptw_ren && !dmem_req && !m_busy) break;
      end
      chk("cont_count", n, 64'd2);
      chk("cont_first_addr", hs_addr[0], 64'h2000);
      chk("cont_first_we", hs_we[0], 1'b0);
      chk("cont_second_addr", hs_addr[1], 64'h100);
      chk("cont_second_we", hs_we[1], 1'b1);
      chk("cont_second_mask", hs_mask[1], 8'h0F);
      chk("cont_second_wdata", hs_wdata[1], 64'h11);

      // Backpressure: ready low five cycles, then a single handshake.
      auto_mem = 0; mem_req_ready = 0; mem_resp_valid = 0;
      dmem_req = 1; dmem_we = 0; dmem_addr = 64'h200; dmem_wdata = '0; dmem_wmask = 8'hFF;
      hs0 = hs_count;
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_valid", obs_valid, 1'b1);
         chk("bp_addr", obs_addr, 64'h200);
         chk("bp_mask", obs_wmask, 8'hFF);
      end
      mem_req_ready = 1; tick();
      mem_req_ready = 0; tick();
      chk("bp_no_dup", obs_valid, 1'b0);
      mem_resp_valid = 1; mem_rdata = 64'h55; tick();
      mem_resp_valid = 0; tick();
      chk("bp_stall_low", obs_dmem_stall, 1'b0);
      chk("bp_rdata", obs_dmem_rdata, 64'h55);
      chk("bp_handshakes", hs_count - hs0, 64'd1);
      dmem_req = 0;

      // Abort: walker drops in RESP; its response is discarded and dmem goes next.
      ptw_ren = 1; ptw_addr = 64'h3000;
      dmem_req = 1; dmem_we = 0; dmem_addr = 64'h400;
      mem_req_ready = 1;
      tick();
      saved = obs_ptw_rdata;
      tick();
      mem_req_ready = 0; ptw_ren = 0;
      tick();
      mem_resp_valid = 1; mem_rdata = 64'hDEAD;
      tick();
      mem_resp_valid = 0; ptw_ren = 1;
      tick();
      chk("abort_no_done", obs_ptw_stall, 1'b1);
      chk("abort_rdata_kept", obs_ptw_rdata, saved);
      tick();
      chk("abort_next_valid", obs_valid, 1'b1);
      chk("abort_next_dmem", obs_addr, 64'h400);
      drain();

      // Reset while a request waits for ready; a stray response afterwards is ignored.
      auto_mem = 0; mem_req_ready = 0; mem_resp_valid = 0;
      dmem_req = 1; dmem_we = 0; dmem_addr = 64'h500;
      tick(); tick();
      chk("rst_pre_valid", obs_valid, 1'b1);
      rst = 0; tick();
      rst = 1; dmem_req = 0; mem_resp_valid = 1; mem_rdata = 64'hBAD;
      tick();
      chk("rst_valid_clear", obs_valid, 1'b0);
      mem_resp_valid = 0;
      tick();
      chk("rst_stray_ignored", obs_dmem_rdata, 64'h0);
      chk("rst_still_idle", obs_valid, 1'b0);

      // Randomized traffic against the model.
      auto_mem = 1;
      for (int c = 0; c < 3000; c++) begin
         drive_reqs(1'b1);
         tick();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
